// File: rtl/pch_unit.sv
// Program-counter high byte for the 65C02 core: holds PCH, follows PCL carries and
// applies the +1/-1 page-cross fix-up after a taken relative branch.
module pch_unit #(
    parameter logic [7:0] RESET_PCH = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_pch_db,
    input  logic [7:0] db_in,
    input  logic       load_pch_abh,
    input  logic [7:0] address_high_in,
    input  logic       increment_pc,
    input  logic       carry_to_pch,
    input  logic       branch_taken,
    input  logic       branch_carry,
    input  logic       offset_sign,
    output logic [7:0] db_out,
    output logic [7:0] address_high_out,
    output logic       stall,
    output logic       pch_wrap
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FIX  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pch_q, pch_d;
    logic       adj_up_q, adj_up_d;
    logic       stall_q, stall_d;
    logic       wrap_q, wrap_d;

    // Next-state, PCH update and registered-output decode
    always_comb begin
        state_d  = state_q;
        pch_d    = pch_q;
        adj_up_d = adj_up_q;
        wrap_d   = 1'b0;
        if (load_pch_db) begin
            pch_d   = db_in;
            state_d = ST_IDLE;
        end else if (load_pch_abh) begin
            pch_d   = address_high_in;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_FIX: begin
                    // Only a +1 adjust can wrap FF->00; a -1 adjust never pulses.
                    if (adj_up_q) begin
                        pch_d  = pch_q + 8'd1;
                        wrap_d = (pch_q == 8'hFF);
                    end else begin
                        pch_d  = pch_q - 8'd1;
                        wrap_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (increment_pc && carry_to_pch) begin
                        pch_d  = pch_q + 8'd1;
                        wrap_d = (pch_q == 8'hFF);
                    end else begin
                        pch_d  = pch_q;
                    end
                    if (branch_taken && !offset_sign && branch_carry) begin
                        adj_up_d = 1'b1;
                        state_d  = ST_FIX;
                    end else if (branch_taken && offset_sign && !branch_carry) begin
                        adj_up_d = 1'b0;
                        state_d  = ST_FIX;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        stall_d = (state_d == ST_FIX);
    end

    // State, PCH and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pch_q    <= RESET_PCH;
            adj_up_q <= 1'b0;
            stall_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pch_q    <= pch_d;
            adj_up_q <= adj_up_d;
            stall_q  <= stall_d;
            wrap_q   <= wrap_d;
        end
    end

    assign db_out           = pch_q;
    assign address_high_out = pch_q;
    assign stall            = stall_q;
    assign pch_wrap         = wrap_q;

endmodule

// File: tb/tb_pch_unit.sv
// Self-checking bench for pch_unit: directed scenarios plus random strobes
// compared against an integer-arithmetic reference model.
module tb_pch_unit;

    logic       clk;
    logic       reset;
    logic       load_pch_db;
    logic [7:0] db_in;
    logic       load_pch_abh;
    logic [7:0] address_high_in;
    logic       increment_pc;
    logic       carry_to_pch;
    logic       branch_taken;
    logic       branch_carry;
    logic       offset_sign;
    logic [7:0] db_out;
    logic [7:0] address_high_out;
    logic       stall;
    logic       pch_wrap;

    int checks_r = 0;
    int errors_r = 0;

    // Reference model: PCH as an integer, pending page-cross adjust as -1/0/+1
    int m_pch  = 255;
    int m_pend = 0;
    int m_wrap = 0;

    pch_unit #(.RESET_PCH(8'hFF)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_pch_db     (load_pch_db),
        .db_in           (db_in),
        .load_pch_abh    (load_pch_abh),
        .address_high_in (address_high_in),
        .increment_pc    (increment_pc),
        .carry_to_pch    (carry_to_pch),
        .branch_taken    (branch_taken),
        .branch_carry    (branch_carry),
        .offset_sign     (offset_sign),
        .db_out          (db_out),
        .address_high_out(address_high_out),
        .stall           (stall),
        .pch_wrap        (pch_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_val({tag, ".db_out"}, {24'd0, db_out}, m_pch);
        check_val({tag, ".abh_out"}, {24'd0, address_high_out}, m_pch);
        check_val({tag, ".stall"}, {31'd0, stall}, (m_pend != 0) ? 32'd1 : 32'd0);
        check_val({tag, ".wrap"}, {31'd0, pch_wrap}, m_wrap);
    endtask

    task automatic model_edge(input logic ldb, input logic [7:0] db, input logic labh,
                              input logic [7:0] ah, input logic inc, input logic cty,
                              input logic bt, input logic bc, input logic sgn);
        m_wrap = 0;
        if (ldb) begin
            m_pch = db; m_pend = 0;
        end else if (labh) begin
            m_pch = ah; m_pend = 0;
        end else if (m_pend != 0) begin
            m_wrap = (m_pend == 1 && m_pch == 255) ? 1 : 0;
            m_pch  = (m_pch + m_pend + 256) % 256;
            m_pend = 0;
        end else begin
            if (inc && cty) begin
                m_wrap = (m_pch == 255) ? 1 : 0;
                m_pch  = (m_pch + 1) % 256;
            end
            if (bt && !sgn && bc) m_pend = 1;
            else if (bt && sgn && !bc) m_pend = -1;
        end
    endtask

    task automatic step(input string tag, input logic ldb, input logic [7:0] db, input logic labh,
                        input logic [7:0] ah, input logic inc, input logic cty,
                        input logic bt, input logic bc, input logic sgn);
        load_pch_db = ldb; db_in = db; load_pch_abh = labh; address_high_in = ah;
        increment_pc = inc; carry_to_pch = cty;
        branch_taken = bt; branch_carry = bc; offset_sign = sgn;
        @(posedge clk);
        model_edge(ldb, db, labh, ah, inc, cty, bt, bc, sgn);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [7:0] v);
        step(tag, 1'b1, v, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic branch(input string tag, input logic bc, input logic sgn);
        step(tag, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, bc, sgn);
    endtask

    initial begin
        reset = 1'b1;
        load_pch_db = 1'b0; db_in = 8'h00; load_pch_abh = 1'b0; address_high_in = 8'h00;
        increment_pc = 1'b0; carry_to_pch = 1'b0;
        branch_taken = 1'b0; branch_carry = 1'b0; offset_sign = 1'b0;
        #1;
        check_val("por.pch", {24'd0, db_out}, 32'h0000_00FF);
        check_val("por.stall", {31'd0, stall}, 32'd0);
        #1 reset = 1'b0;

        // Reset asserted mid fix-up takes effect without a clock edge
        load("t1.load", 8'h12);
        branch("t1.br", 1'b1, 1'b0);
        check_val("t1.in_fix", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        m_pch = 255; m_pend = 0; m_wrap = 0;
        check_val("t1.rst_pch", {24'd0, db_out}, 32'h0000_00FF);
        check_val("t1.rst_abh", {24'd0, address_high_out}, 32'h0000_00FF);
        check_val("t1.rst_stall", {31'd0, stall}, 32'd0);
        check_val("t1.rst_wrap", {31'd0, pch_wrap}, 32'd0);
        #1 reset = 1'b0;
        idle("t1.hold");
        check_val("t1.hold_ff", {24'd0, db_out}, 32'h0000_00FF);

        // Increment only advances with a PCL carry
        load("t2.load", 8'h12);
        for (int i = 0; i < 3; i++)
            step("t2.nocarry", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t2.still12", {24'd0, db_out}, 32'h0000_0012);
        step("t2.carry_noinc", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2.carry", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t2.is13", {24'd0, db_out}, 32'h0000_0013);

        // Wrap by increment pulses for one cycle only
        load("t3.load", 8'hFF);
        step("t3.inc", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t3.pch00", {24'd0, db_out}, 32'd0);
        check_val("t3.wrap1", {31'd0, pch_wrap}, 32'd1);
        idle("t3.after");
        check_val("t3.wrap0", {31'd0, pch_wrap}, 32'd0);

        // Page-cross fix-ups forward, backward and none
        load("t4.ld_a", 8'h40);
        branch("t4.fwd", 1'b1, 1'b0);
        check_val("t4.fwd_stall", {31'd0, stall}, 32'd1);
        idle("t4.fwd_fix");
        check_val("t4.is41", {24'd0, db_out}, 32'h0000_0041);
        check_val("t4.fwd_unstall", {31'd0, stall}, 32'd0);
        load("t4.ld_b", 8'h40);
        branch("t4.back", 1'b0, 1'b1);
        idle("t4.back_fix");
        check_val("t4.is3f", {24'd0, db_out}, 32'h0000_003F);
        load("t4.ld_c", 8'h40);
        branch("t4.none", 1'b0, 1'b0);
        check_val("t4.none_stall", {31'd0, stall}, 32'd0);
        check_val("t4.is40", {24'd0, db_out}, 32'h0000_0040);
        branch("t4.none2", 1'b1, 1'b1);
        check_val("t4.none2_stall", {31'd0, stall}, 32'd0);

        // Load during FIX aborts the adjust
        load("t5.load", 8'h40);
        branch("t5.fwd", 1'b1, 1'b0);
        step("t5.abh", 1'b0, 8'h00, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t5.is90", {24'd0, db_out}, 32'h0000_0090);
        check_val("t5.stall0", {31'd0, stall}, 32'd0);
        idle("t5.hold");
        check_val("t5.hold90", {24'd0, db_out}, 32'h0000_0090);

        // Load priority; strobes inside FIX are ignored
        step("t6.both", 1'b1, 8'h22, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t6.is22", {24'd0, db_out}, 32'h0000_0022);
        check_val("t6.ld_br_ignored", {31'd0, stall}, 32'd0);
        branch("t6.fwd", 1'b1, 1'b0);
        step("t6.fix_inc", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("t6.is23", {24'd0, db_out}, 32'h0000_0023);
        check_val("t6.no_rebranch", {31'd0, stall}, 32'd0);

        // Adjust across page edges: +1 from FF pulses, -1 from 00 does not
        load("t7.ld_ff", 8'hFF);
        branch("t7.fwd", 1'b1, 1'b0);
        idle("t7.fix");
        check_val("t7.wrap_up", {31'd0, pch_wrap}, 32'd1);
        load("t7.ld_00", 8'h00);
        branch("t7.back", 1'b0, 1'b1);
        idle("t7.fix_b");
        check_val("t7.isff", {24'd0, db_out}, 32'h0000_00FF);
        check_val("t7.nowrap", {31'd0, pch_wrap}, 32'd0);

        // Random strobes against the model
        for (int i = 0; i < 600; i++) begin
            logic ldb, labh, inc, cty, bt, bc, sgn;
            logic [7:0] db, ah;
            ldb  = ($urandom_range(0, 11) == 0);
            labh = ($urandom_range(0, 11) == 0);
            db   = 8'($urandom);
            ah   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            inc  = 1'($urandom);
            cty  = ($urandom_range(0, 1) == 0);
            bt   = ($urandom_range(0, 3) == 0);
            bc   = 1'($urandom);
            sgn  = 1'($urandom);
            step("rnd", ldb, db, labh, ah, inc, cty, bt, bc, sgn);
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
